// File: rtl/if1_fetch_ctrl.sv
// Instruction fetch producer: one outstanding ICache request at a time,
// latches each two-word response with pre-decode flags, pushes it to the fetch buffer.
module if1_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h1c000000,
  parameter logic [31:0] INST_NOP = 32'h03400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_req_ready,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst0,
  input  logic [31:0] icache_resp_inst1,
  input  logic [31:0] icache_resp_badv,
  input  logic [31:0] icache_resp_cookie,
  input  logic [6:0]  icache_resp_exception,
  input  logic [1:0]  icache_resp_excp_flag,
  input  logic        fifo_allowin,
  output logic        fifo_readygo,
  output logic [31:0] if1_fifo_inst0,
  output logic [31:0] if1_fifo_inst1,
  output logic [31:0] if1_fifo_pc,
  output logic [31:0] if1_fifo_pc_next,
  output logic [31:0] if1_fifo_icache_badv,
  output logic [31:0] if1_fifo_icache_cookie_out,
  output logic [6:0]  if1_fifo_icache_exception,
  output logic [1:0]  if1_fifo_icache_excp_flag,
  output logic [1:0]  priv_flag,
  output logic [1:0]  branch_flag,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a request transfers on a cycle with icache_req_valid && icache_req_ready;
  // an entry transfers on a cycle with fifo_readygo (which already includes fifo_allowin).

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_HALT = 3'd4,
    S_DROP = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        latch_en;

  logic [31:0] inst0_q, inst1_q, fpc_q, fpc_next_q, badv_q, cookie_q;
  logic [6:0]  exc_q;
  logic [1:0]  xflag_q, priv_q, branch_q;

  logic        unaligned;
  logic [31:0] blk_base, slot0, slot1, pc_next_calc;

  function automatic logic is_priv(input logic [15:0] hi);
    return (hi[15:8] == 8'h04) || (hi == 16'h0648);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= 6'h13) && (op <= 6'h1b);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    latch_en = 1'b0;
    if (flush) pc_d = flush_target;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (icache_req_ready) state_d = flush ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = icache_resp_valid ? S_REQ : S_DROP;
        end else if (icache_resp_valid) begin
          latch_en = 1'b1;
          state_d  = S_PUSH;
        end
      end
      S_PUSH: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (fifo_allowin) begin
          if (xflag_q != 2'b00) begin
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
            pc_d    = fpc_next_q;
          end
        end
      end
      S_HALT: begin
        if (flush) state_d = S_REQ;
      end
      S_DROP: begin
        // The stale response retires the old request whether or not another flush arrives.
        if (icache_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    icache_req_valid = (state_q == S_REQ);
    icache_req_addr  = {pc_q[31:3], 3'b000};
    fifo_readygo     = (state_q == S_PUSH) && fifo_allowin && !flush;
    dbg_state_o      = state_q;
  end

  always_comb begin
    unaligned    = pc_q[2];
    blk_base     = {pc_q[31:3], 3'b000};
    slot0        = unaligned ? icache_resp_inst1 : icache_resp_inst0;
    slot1        = unaligned ? INST_NOP : icache_resp_inst1;
    pc_next_calc = unaligned ? (blk_base + 32'd8) : (pc_q + 32'd8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst0_q    <= '0;
      inst1_q    <= '0;
      fpc_q      <= '0;
      fpc_next_q <= '0;
      badv_q     <= '0;
      cookie_q   <= '0;
      exc_q      <= '0;
      xflag_q    <= '0;
      priv_q     <= '0;
      branch_q   <= '0;
    end else if (latch_en) begin
      inst0_q    <= slot0;
      inst1_q    <= slot1;
      fpc_q      <= pc_q;
      fpc_next_q <= pc_next_calc;
      badv_q     <= icache_resp_badv;
      cookie_q   <= icache_resp_cookie;
      exc_q      <= icache_resp_exception;
      xflag_q    <= icache_resp_excp_flag;
      priv_q     <= {is_priv(slot1[31:16]), is_priv(slot0[31:16])};
      branch_q   <= {is_branch(slot1[31:26]), is_branch(slot0[31:26])};
    end
  end

  assign if1_fifo_inst0             = inst0_q;
  assign if1_fifo_inst1             = inst1_q;
  assign if1_fifo_pc                = fpc_q;
  assign if1_fifo_pc_next           = fpc_next_q;
  assign if1_fifo_icache_badv       = badv_q;
  assign if1_fifo_icache_cookie_out = cookie_q;
  assign if1_fifo_icache_exception  = exc_q;
  assign if1_fifo_icache_excp_flag  = xflag_q;
  assign priv_flag                  = priv_q;
  assign branch_flag                = branch_q;

endmodule
